// File: rtl/cpu_regs_sb.sv
// cpu_regs_sb -- multi-read-port register file with a busy-bit scoreboard.
//
// Sits between decode and writeback. Decode reads operands through NREAD
// registered read ports and reserves its destination (issue). Writeback
// commits data and releases the reservation. Read data and busy flags are
// registered, so this block is one pipeline stage and honours
// stall_pipeline.
//
// Build option:
//   CPU_REGS_BYPASS_EN  when defined, a read that samples on the same edge as
//                       a matching writeback returns the written data and the
//                       post-update busy bit. When undefined, that read
//                       returns the pre-edge contents.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   stall_pipeline   freezes the read stage and issue reservation
//   ra   [NREAD*AW]  read addresses, port i at ra[i*AW +: AW]
//   q    [NREAD*W]   registered read data, port i at q[i*WIDTH +: WIDTH]
//   q_busy [NREAD]   registered busy flag per read port
//   hazard           OR of q_busy
//   issue_v/issue_rd reserve a destination register
//   wb_v/wb_rd/d     writeback
//   busy_cnt [AW+1]  number of busy registers
//
// Register 0 reads as zero, is never busy, and ignores writes and issues.

// One registered read port. The forwarding path is gated by fwd_en, which
// the top ties to the build option, so the unused path folds away.
module cpu_regs_sb_rport #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_pipeline,
  input  logic [AW-1:0]               ra,
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [NREGS-1:0]            busy_cur,
  input  logic [NREGS-1:0]            busy_nxt,
  input  logic                        fwd_en,
  input  logic [AW-1:0]               wb_rd,
  input  logic [WIDTH-1:0]            d,
  output logic [WIDTH-1:0]            q,
  output logic                        q_busy
);

  logic [WIDTH-1:0] rd_val;
  logic             rd_busy;

  always_comb begin
    rd_val  = regs[ra];
    rd_busy = busy_cur[ra];
    // fwd_en already excludes register 0, so no ra==0 check is needed here.
    if (fwd_en && (wb_rd == ra)) begin
      rd_val  = d;
      rd_busy = busy_nxt[ra];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      q_busy <= 1'b0;
    end else if (!stall_pipeline) begin
      q      <= rd_val;
      q_busy <= rd_busy;
    end
  end

endmodule

module cpu_regs_sb #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipeline,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] q,
  output logic [NREAD-1:0]       q_busy,
  output logic                   hazard,
  input  logic                   issue_v,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   wb_v,
  input  logic [AW-1:0]          wb_rd,
  input  logic [WIDTH-1:0]       d,
  output logic [AW:0]            busy_cnt
);

`ifdef CPU_REGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            busy;
  logic [NREGS-1:0]            busy_nxt;
  logic                        wb_en;
  logic                        issue_en;
  logic                        fwd_en;
  logic                        cnt_inc;
  logic                        cnt_dec;

  assign wb_en    = wb_v && (wb_rd != '0);
  assign issue_en = issue_v && !stall_pipeline && (issue_rd != '0);
  assign fwd_en   = BYPASS && wb_en;

  // Issue is applied after writeback so a same-register pair leaves the
  // newer reservation in place.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)    busy_nxt[wb_rd]    = 1'b0;
    if (issue_en) busy_nxt[issue_rd] = 1'b1;
  end

  // Incremental popcount: at most one bit sets and one clears per cycle.
  // A writeback that collides with a same-register issue never decrements.
  assign cnt_inc = issue_en && !busy[issue_rd];
  assign cnt_dec = wb_en && busy[wb_rd] && !(issue_en && (issue_rd == wb_rd));

  always_ff @(posedge clk) begin
    if (rst) begin
      regs     <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_en) regs[wb_rd] <= d;
      busy <= busy_nxt;
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt <= busy_cnt + 1'b1;
        2'b01:   busy_cnt <= busy_cnt - 1'b1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    cpu_regs_sb_rport #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rport (
      .clk            (clk),
      .rst            (rst),
      .stall_pipeline (stall_pipeline),
      .ra             (ra[i*AW +: AW]),
      .regs           (regs),
      .busy_cur       (busy),
      .busy_nxt       (busy_nxt),
      .fwd_en         (fwd_en),
      .wb_rd          (wb_rd),
      .d              (d),
      .q              (q[i*WIDTH +: WIDTH]),
      .q_busy         (q_busy[i])
    );
  end

  assign hazard = |q_busy;

endmodule

// File: tb/tb_cpu_regs_sb.sv
// Directed table-driven bench for cpu_regs_sb (WIDTH=32, NREGS=32, NREAD=2).
// Expected values that differ between the forwarding and non-forwarding
// builds are selected with BYP.
module tb_cpu_regs_sb;

`ifdef CPU_REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pipeline;
  logic [9:0]  ra;
  logic [63:0] q;
  logic [1:0]  q_busy;
  logic        hazard;
  logic        issue_v;
  logic [4:0]  issue_rd;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] d;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_regs_sb dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pipeline (stall_pipeline),
    .ra             (ra),
    .q              (q),
    .q_busy         (q_busy),
    .hazard         (hazard),
    .issue_v        (issue_v),
    .issue_rd       (issue_rd),
    .wb_v           (wb_v),
    .wb_rd          (wb_rd),
    .d              (d),
    .busy_cnt       (busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] d;
    logic [31:0] q0;
    logic [31:0] q1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, int a0, int a1, bit iv, int ird,
                              bit wv, int wrd, logic [31:0] dd,
                              logic [31:0] q0, logic [31:0] q1, bit b0, bit b1,
                              int cnt);
    vec_t v;
    v.rst = r;   v.stall = s;  v.ra0 = 5'(a0); v.ra1 = 5'(a1);
    v.iv = iv;   v.ird = 5'(ird); v.wv = wv;   v.wrd = 5'(wrd);
    v.d = dd;    v.q0 = q0;    v.q1 = q1;      v.b0 = b0; v.b1 = b1;
    v.cnt = 6'(cnt);
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs 1ns after the edge.
  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; stall_pipeline = v.stall;
    ra = {v.ra1, v.ra0};
    issue_v = v.iv; issue_rd = v.ird;
    wb_v = v.wv; wb_rd = v.wrd; d = v.d;
    @(posedge clk);
    #1;
    chk("q0",       idx, q[31:0],            v.q0);
    chk("q1",       idx, q[63:32],           v.q1);
    chk("q_busy",   idx, 32'(q_busy),        32'({v.b1, v.b0}));
    chk("hazard",   idx, 32'(hazard),        32'(v.b0 | v.b1));
    chk("busy_cnt", idx, 32'(busy_cnt),      32'(v.cnt));
  endtask

  initial begin
    rst = 1'b1; stall_pipeline = 1'b0; ra = '0;
    issue_v = 1'b0; issue_rd = '0; wb_v = 1'b0; wb_rd = '0; d = '0;

    //           r s ra0 ra1 iv ird wv wrd d      q0                       q1                       b0       b1 cnt
    tbl.push_back(mk(1,0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,                   32'h0,                   0,       0, 0));
    // write 7 with same-edge read of 7
    tbl.push_back(mk(0,0, 7, 0, 0, 0, 1, 7, 32'hAF, BYP ? 32'hAF : 32'h0,    32'h0,                   0,       0, 0));
    // write to reg 0 ignored
    tbl.push_back(mk(0,0, 7, 0, 0, 0, 1, 0, 32'hFF, 32'hAF,                  32'h0,                   0,       0, 0));
    // same-edge forward on port 1
    tbl.push_back(mk(0,0, 0, 7, 0, 0, 1, 7, 32'hFF, 32'h0,                   BYP ? 32'hFF : 32'hAF,   0,       0, 0));
    tbl.push_back(mk(0,0, 0, 7, 0, 0, 0, 0, 32'h0,  32'h0,                   32'hFF,                  0,       0, 0));
    // scoreboard: issue 5 (no writeback -> read sees pre-edge busy)
    tbl.push_back(mk(0,0, 5, 7, 1, 5, 0, 0, 32'h0,  32'h0,                   32'hFF,                  0,       0, 1));
    tbl.push_back(mk(0,0, 5, 7, 0, 0, 0, 0, 32'h0,  32'h0,                   32'hFF,                  1,       0, 1));
    // issue+writeback same register: stays busy, data written
    tbl.push_back(mk(0,0, 5, 7, 1, 5, 1, 5, 32'h33, BYP ? 32'h33 : 32'h0,    32'hFF,                  1,       0, 1));
    // lone writeback releases
    tbl.push_back(mk(0,0, 5, 7, 0, 0, 1, 5, 32'h44, BYP ? 32'h44 : 32'h33,   32'hFF,                  !BYP,    0, 0));
    tbl.push_back(mk(0,0, 5, 7, 0, 0, 0, 0, 32'h0,  32'h44,                  32'hFF,                  0,       0, 0));
    // set up hazard before stall
    tbl.push_back(mk(0,0, 7, 2, 1, 2, 0, 0, 32'h0,  32'hFF,                  32'h0,                   0,       0, 1));
    tbl.push_back(mk(0,0, 7, 2, 0, 0, 0, 0, 32'h0,  32'hFF,                  32'h0,                   0,       1, 1));
    // 3 stalled cycles: outputs hold, issue blocked, writeback lands
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1, 3, 9, 1, 9, 1, 3, 32'h12, 32'hFF,                32'h0,                   0,       1, 1));
    tbl.push_back(mk(0,0, 3, 9, 0, 0, 0, 0, 32'h0,  32'h12,                  32'h0,                   0,       0, 1));
    // reset with same-cycle writeback and issue
    tbl.push_back(mk(1,0, 4, 6, 1, 6, 1, 4, 32'h55, 32'h0,                   32'h0,                   0,       0, 0));
    tbl.push_back(mk(0,0, 4, 6, 0, 0, 0, 0, 32'h0,  32'h0,                   32'h0,                   0,       0, 0));
    tbl.push_back(mk(0,0, 7, 2, 0, 0, 0, 0, 32'h0,  32'h0,                   32'h0,                   0,       0, 0));
    // issue and write to reg 0 both ignored
    tbl.push_back(mk(0,0, 0, 0, 1, 0, 1, 0, 32'hFF, 32'h0,                   32'h0,                   0,       0, 0));
    // double issue to 8 counts once
    tbl.push_back(mk(0,0, 8, 0, 1, 8, 0, 0, 32'h0,  32'h0,                   32'h0,                   0,       0, 1));
    tbl.push_back(mk(0,0, 8, 0, 1, 8, 0, 0, 32'h0,  32'h0,                   32'h0,                   1,       0, 1));
    tbl.push_back(mk(0,0, 0, 8, 0, 0, 1, 8, 32'h99, 32'h0,                   BYP ? 32'h99 : 32'h0,    0,    !BYP, 0));
    tbl.push_back(mk(0,0, 0, 8, 0, 0, 0, 0, 32'h0,  32'h0,                   32'h99,                  0,       0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted while stalled clears held outputs, then stall holds zero.
    apply(mk(0,0,10, 0, 1,10, 0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 1), 100);
    apply(mk(0,0,10, 0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0, 1, 0, 1), 101);
    apply(mk(1,1,11, 0, 1,11, 1,10, 32'h77, 32'h0, 32'h0, 0, 0, 0), 102);
    apply(mk(0,1,10, 0, 1,11, 0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0), 103);
    apply(mk(0,0,10,11, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0, 0, 0, 0), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_regs_sb.md
# cpu_regs_sb

Parametrised multi-read-port CPU register file with an integrated busy-bit scoreboard and optional write-through forwarding. It sits between decode and writeback: decode reads operands and reserves its destination, and writeback commits results and releases the reservation. Read data and busy flags are registered, so the block is a pipeline stage and honours the pipeline stall.

## Interface

Parameters:
- WIDTH, 32: data word width.
- NREGS, 32: number of architectural registers. Must be a power of two, ≥ 2.
- NREAD, 2: number of read ports, 1..4.
- AW, $clog2(NREGS): register address width. Derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall_pipeline  in  1  freezes the read stage and issue reservation.
- ra  in  NREAD*AW  read addresses; port i is ra[i*AW +: AW].
- q  out  NREAD*WIDTH  registered read data; port i is q[i*WIDTH +: WIDTH].
- q_busy  out  NREAD  registered busy flag of each read port's register.
- hazard  out  1  OR of q_busy.
- issue_v  in  1  reserve a destination register.
- issue_rd  in  AW  destination register to mark busy.
- wb_v  in  1  writeback valid.
- wb_rd  in  AW  writeback register.
- d  in  WIDTH  writeback data.
- busy_cnt  out  AW+1  number of currently busy registers.

## Operation

State:
- regs[1..NREGS-1] (WIDTH bits each).
- busy[1..NREGS-1].
- Register 0 reads as 0 and is never busy. Writes and issues to register 0 are ignored.

Every edge, unless rst:
- Writeback: if wb_v and wb_rd≠0, then regs[wb_rd]←d and busy[wb_rd]←0. Writeback is performed even while stall_pipeline=1.
- Issue: if issue_v and !stall_pipeline and issue_rd≠0, then busy[issue_rd]←1.
- Same-register issue and writeback in the same cycle: busy ends at 1, because the newer reservation wins. Data is still written.
- Read stage: if !stall_pipeline, then for each port i, q[i]←value(ra[i]) and q_busy[i]←busyval(ra[i]). If stall_pipeline=1, q, q_busy and hazard hold.
- busy_cnt tracks the population count of busy after the update. Net change per cycle is -1, 0 or +1.
- Issue to an already-busy register: busy stays 1 and busy_cnt is unchanged.
- Writeback to a non-busy register: data is written and busy_cnt is unchanged.

value(a) and busyval(a) depend on forwarding; see Configuration.

Reset (rst=1 on an edge) dominates all inputs, including mid-stall and same-cycle writeback or issue:
- All regs = 0.
- All busy = 0.
- q = 0, q_busy = 0, hazard = 0, busy_cnt = 0.

## Timing

- Read latency is 1 cycle: ra applied in cycle n appears on q and q_busy after edge n.
- Write-to-read latency for a different cycle is 1 cycle: a writeback at edge n is visible to a read sampled at edge n+1.
- hazard is combinational from the q_busy registers. It has no extra latency.
- busy_cnt is registered and matches busy after each edge.
- Stall: the outputs hold for as many cycles as stall_pipeline stays high. They resume on the first edge with stall_pipeline=0.

## Configuration

- CPU_REGS_BYPASS_EN defined (forwarding compiled in): when a read port samples at the same edge as a writeback with wb_v=1, wb_rd=ra[i] and wb_rd≠0:
  - q[i] gets d.
  - q_busy[i] gets the post-update busy value: 0, unless a same-cycle issue to that register occurred.
- CPU_REGS_BYPASS_EN not defined: that read gets the pre-edge regs value and pre-edge busy bit. The new value is seen one cycle later.
- All other behaviour is identical in both builds.

## Test plan

- Reset: drive rst=1 for one edge after arbitrary writes → all q=0, q_busy=0, hazard=0, busy_cnt=0. Reading every register then returns 0.
- Basic write/read:
  - wb_v=1, wb_rd=7, d=0xAF at edge n; ra0=7 from cycle n+1 → q0=0xAF after edge n+1.
  - wb_rd=0, d=0xFF → register 0 still reads 0.
- Same-edge forwarding: regs[7]=0xAF; in one cycle, wb_rd=7, d=0xFF, ra1=7 → q1=0xFF with CPU_REGS_BYPASS_EN and 0xAF without it. With the macro absent, q1=0xFF one cycle later.
- Scoreboard:
  - issue 5 → q_busy=1, hazard=1, busy_cnt=1 on a read of 5.
  - Issue 5 and writeback 5 in the same cycle → busy stays 1, busy_cnt=1.
  - Lone writeback 5 → busy_cnt=0.
- Stall: stall_pipeline=1 for 3 cycles while ra changes, issue_v=1 (rd=9) and wb (rd=3, d=0x12) occur →
  - q and q_busy hold.
  - busy[9] stays 0.
  - regs[3]=0x12 on read after the stall drops.
- Reset mid-operation: rst=1 in the same cycle as wb_v=1 (rd=4, d=0x55) and issue_v=1 (rd=6) → regs[4]=0, busy[6]=0, busy_cnt=0.
